ri_type: RTL and testbench

RI_TYPE -- requirements
Module: ri_type

---
 rtl/ri_type_pkg.sv | 13 +
 rtl/ri_abs_diff.sv | 26 ++
 rtl/ri_type.sv | 59 +++++
 tb/tb_ri_type.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ri_type_pkg.sv
// Shared constants for the run-interruption type block: mode encodings and
// default sample/mode widths.
package ri_type_pkg;

   localparam int PIXEL_LENGTH_DEF = 8;
   localparam int MODE_LENGTH_DEF  = 2;

   // Encoding 3 is reserved and decodes the same as a non-RI mode.
   localparam logic [1:0] MODE_REGULAR = 2'd0;
   localparam logic [1:0] MODE_RUN     = 2'd1;
   localparam logic [1:0] MODE_RI      = 2'd2;

endpackage

// File: rtl/ri_abs_diff.sv
// Combinational neighbour compare: a>b flag plus the "close enough" flag.
// Build macro RI_TYPE_NEAR_EN selects |a-b| <= NEAR; otherwise exact a == b.
module ri_abs_diff #(
   parameter int PIXEL_LENGTH = 8,
   parameter int NEAR         = 0
) (
   input  logic [PIXEL_LENGTH-1:0] i_a,
   input  logic [PIXEL_LENGTH-1:0] i_b,
   output logic                    o_a_gt_b,
   output logic                    o_near
);

   assign o_a_gt_b = (i_a > i_b);

`ifdef RI_TYPE_NEAR_EN
   // One extra bit keeps the magnitude exact at the extremes (0 vs max).
   logic [PIXEL_LENGTH:0] w_abs;

   assign w_abs  = o_a_gt_b ? ({1'b0, i_a} - {1'b0, i_b})
                            : ({1'b0, i_b} - {1'b0, i_a});
   assign o_near = (32'(w_abs) <= NEAR);
`else
   assign o_near = (i_a == i_b);
`endif

endmodule

// File: rtl/ri_type.sv
// Run-interruption type decision: registers RIType and the a>b sign flag one
// cycle after each valid sample. Near-lossless test enabled by RI_TYPE_NEAR_EN.
module ri_type
   import ri_type_pkg::*;
#(
   parameter int PIXEL_LENGTH = PIXEL_LENGTH_DEF,
   parameter int MODE_LENGTH  = MODE_LENGTH_DEF,
   parameter int NEAR         = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [PIXEL_LENGTH-1:0] a,
   input  logic [PIXEL_LENGTH-1:0] b,
   input  logic [MODE_LENGTH-1:0]  mode,
   output logic                    out_valid,
   output logic                    RIType,
   output logic                    a_b_compare
);

   logic w_a_gt_b;
   logic w_near;
   logic w_is_ri;
   logic r_out_valid;
   logic r_ritype;
   logic r_a_b_compare;

   ri_abs_diff #(
      .PIXEL_LENGTH (PIXEL_LENGTH),
      .NEAR         (NEAR)
   ) u_abs_diff (
      .i_a      (a),
      .i_b      (b),
      .o_a_gt_b (w_a_gt_b),
      .o_near   (w_near)
   );

   assign w_is_ri = (mode == MODE_LENGTH'(MODE_RI));

   // Results only update on a valid sample; idle cycles hold the last decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_ritype      <= 1'b0;
         r_a_b_compare <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_ritype      <= w_is_ri & w_near;
            r_a_b_compare <= w_is_ri & w_a_gt_b;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign RIType      = r_ritype;
   assign a_b_compare = r_a_b_compare;

endmodule

// File: tb/tb_ri_type.sv
// Scoreboard bench for ri_type: stimulus pushes expected {RIType, a_b_compare},
// a negedge monitor pops and compares whenever out_valid is high.
module tb_ri_type;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] mode;
   logic       out_valid;
   logic       RIType;
   logic       a_b_compare;

   int n_checks = 0;
   int n_fails  = 0;
   logic [1:0] exp_q[$];

   ri_type #(.PIXEL_LENGTH(8), .MODE_LENGTH(2), .NEAR(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .a           (a),
      .b           (b),
      .mode        (mode),
      .out_valid   (out_valid),
      .RIType      (RIType),
      .a_b_compare (a_b_compare)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got {valid,ri,cmp}=%b expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every presented result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", {out_valid, RIType, a_b_compare}, 3'b000);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check("result", {out_valid, RIType, a_b_compare}, {1'b1, e});
         end
      end
   end

   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                       input logic eri, input logic ecmp);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      mode     = tm;
      exp_q.push_back({eri, ecmp});
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      mode     = '0;
      #1;
      check("reset_state", {out_valid, RIType, a_b_compare}, 3'b000);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Basic RI decisions and extremes
      send(8'd100, 8'd100, 2'd2, 1'b1, 1'b0);
      send(8'd200, 8'd17,  2'd2, 1'b0, 1'b1);
      send(8'd0,   8'd255, 2'd2, 1'b0, 1'b0);
      send(8'd255, 8'd0,   2'd2, 1'b0, 1'b1);
      send(8'd0,   8'd0,   2'd2, 1'b1, 1'b0);
      send(8'd255, 8'd255, 2'd2, 1'b1, 1'b0);
      // Non-RI modes force zeros, including reserved encoding
      send(8'd5,   8'd5,   2'd0, 1'b0, 1'b0);
      send(8'd5,   8'd5,   2'd3, 1'b0, 1'b0);
      send(8'd9,   8'd3,   2'd1, 1'b0, 1'b0);
`ifdef RI_TYPE_NEAR_EN
      send(8'd12,  8'd10,  2'd2, 1'b1, 1'b1);
      send(8'd13,  8'd10,  2'd2, 1'b0, 1'b1);
      send(8'd10,  8'd12,  2'd2, 1'b1, 1'b0);
`else
      send(8'd12,  8'd10,  2'd2, 1'b0, 1'b1);
      send(8'd13,  8'd10,  2'd2, 1'b0, 1'b1);
      send(8'd10,  8'd12,  2'd2, 1'b0, 1'b0);
`endif

      // Hold: result RIType=1 then three idle cycles with changing inputs
      send(8'd77, 8'd77, 2'd2, 1'b1, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         a    = 8'(i * 40 + 3);
         b    = 8'd1;
         mode = 2'd2;
         check("hold", {out_valid, RIType, a_b_compare}, 3'b010);
      end

      // Back-to-back stream then mid-cycle reset
      send(8'd50, 8'd20, 2'd2, 1'b0, 1'b1);
      send(8'd20, 8'd50, 2'd2, 1'b0, 1'b0);
      send(8'd33, 8'd33, 2'd2, 1'b1, 1'b0);
      send(8'd90, 8'd10, 2'd2, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      a = 8'd60; b = 8'd40; mode = 2'd2;  // sample dropped by reset
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("reset_async", {out_valid, RIType, a_b_compare}, 3'b000);
      @(posedge clk);
      #3 rst_n = 1'b1;
      a = 8'd44; b = 8'd44; mode = 2'd2;
      #1 check("reset_no_early", {out_valid, RIType, a_b_compare}, 3'b000);
      exp_q.push_back(2'b10);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
